// File: rtl/led_pkg.sv
// Shared types and sizing helpers for the status-LED blocks.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } blink_state_t;

  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ/TICK_HZ cycles; held at zero while disabled.
module led_tick_prescaler import led_pkg::*; #(
  parameter int CLK_HZ  = 27_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int DIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int W   = cnt_w(DIV);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_end_s;

  assign at_end_s = (cnt_q == W'(DIV - 1));
  assign tick_o   = en_i && at_end_s;

  // Next count: clear while disabled, wrap at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (at_end_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink_code_arbiter.sv
// Round-robin sharing of one status LED: each accepted request is played as N pulses plus a gap.
module led_blink_code_arbiter import led_pkg::*; #(
  parameter int NUM_REQ   = 4,
  parameter int CLK_HZ    = 27_000_000,
  parameter int TICK_HZ   = 10,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 3,
  parameter int GAP_TICKS = 10,
  parameter int CNT_W     = 4,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*CNT_W-1:0] req_count_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     led_o,
  output logic                     busy_o,
  output logic [ID_W-1:0]          grant_id_o,
  output logic                     done_o
);

  localparam int PH_MAX = (GAP_TICKS > ((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS)) ?
                          GAP_TICKS : ((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS);
  localparam int PH_W   = cnt_w(PH_MAX);

  blink_state_t       state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0]   pulses_q, pulses_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [NUM_REQ-1:0] ready_s;
  logic [ID_W-1:0]    pick_s;
  logic               pick_found_s;
  logic [CNT_W-1:0]   pick_count_s;
  logic               tick_s;

  led_tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q != IDLE),
    .tick_o (tick_s)
  );

  // Round-robin picker: first valid requester scanning from ptr; index wraps at NUM_REQ-1.
  always_comb begin
    int idx_v;
    idx_v        = 0;
    ready_s      = '0;
    pick_s       = '0;
    pick_found_s = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx_v = int'(ptr_q) + k;
        if (idx_v >= NUM_REQ) begin
          idx_v = idx_v - NUM_REQ;
        end else begin
          idx_v = idx_v;
        end
        if (!pick_found_s && req_valid_i[idx_v]) begin
          pick_found_s = 1'b1;
          pick_s       = ID_W'(idx_v);
        end else begin
          pick_found_s = pick_found_s;
        end
      end
      ready_s[pick_s] = pick_found_s;
    end else begin
      ready_s = '0;
    end
  end

  assign pick_count_s = req_count_i[int'(pick_s)*CNT_W +: CNT_W];

  // Sequencer next state: accept in IDLE, then ON/OFF pulses, last ON exits to GAP.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    pulses_d = pulses_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (pick_found_s) begin
          grant_d = pick_s;
          ptr_d   = (pick_s == ID_W'(NUM_REQ - 1)) ? '0 : pick_s + ID_W'(1);
          if (pick_count_s == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = ON;
            pulses_d = pick_count_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ON: begin
        if (tick_s && (phase_q == PH_W'(ON_TICKS - 1))) begin
          phase_d  = '0;
          pulses_d = pulses_q - CNT_W'(1);
          state_d  = (pulses_q == CNT_W'(1)) ? GAP : OFF;
        end else if (tick_s) begin
          phase_d = phase_q + PH_W'(1);
        end else begin
          phase_d = phase_q;
        end
      end
      OFF: begin
        if (tick_s && (phase_q == PH_W'(OFF_TICKS - 1))) begin
          phase_d = '0;
          state_d = ON;
        end else if (tick_s) begin
          phase_d = phase_q + PH_W'(1);
        end else begin
          phase_d = phase_q;
        end
      end
      GAP: begin
        if (tick_s && (phase_q == PH_W'(GAP_TICKS - 1))) begin
          phase_d = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tick_s) begin
          phase_d = phase_q + PH_W'(1);
        end else begin
          phase_d = phase_q;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  assign led_d  = (state_d == ON);
  assign busy_d = (state_d != IDLE);

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      pulses_q <= '0;
      grant_q  <= '0;
      ptr_q    <= '0;
      led_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      pulses_q <= pulses_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign req_ready_o = ready_s;
  assign led_o       = led_q;
  assign busy_o      = busy_q;
  assign grant_id_o  = grant_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_led_blink_code_arbiter.sv
// Directed bench for led_blink_code_arbiter with TICK_DIV=10, ON=2, OFF=3, GAP=10 ticks.
module tb_led_blink_code_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_count;
  logic [3:0]  req_ready;
  logic        led;
  logic        busy;
  logic [1:0]  grant_id;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  led_blink_code_arbiter #(
    .NUM_REQ   (4),
    .CLK_HZ    (100),
    .TICK_HZ   (10),
    .ON_TICKS  (2),
    .OFF_TICKS (3),
    .GAP_TICKS (10),
    .CNT_W     (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_count_i (req_count),
    .req_ready_o (req_ready),
    .led_o       (led),
    .busy_o      (busy),
    .grant_id_o  (grant_id),
    .done_o      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  initial begin
    logic exp_led;
    int   last_done;
    int   bad;
    logic got;
    int   exp_id;

    // 1: reset with every requester valid
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_count = 16'h0000;
    nclk(); nclk();
    chk("rst_led", {31'd0, led}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_grant", {30'd0, grant_id}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready0", {28'd0, req_ready}, 32'd1);
    req_valid = 4'h0;
    nclk();

    // 2: single code of 3 pulses from requester 0
    req_count[3:0] = 4'd3;
    req_valid      = 4'b0001;
    #1;
    chk("single_ready", {28'd0, req_ready}, 32'd1);
    for (int n = 1; n <= 222; n++) begin
      nclk();
      exp_led = ((n >= 1) && (n <= 20)) || ((n >= 51) && (n <= 70)) || ((n >= 101) && (n <= 120));
      chk($sformatf("single_led_%0d", n), {31'd0, led}, {31'd0, exp_led});
      chk($sformatf("single_done_%0d", n), {31'd0, done}, {31'd0, (n == 221)});
      chk($sformatf("single_busy_%0d", n), {31'd0, busy}, {31'd0, (n <= 220)});
      if (n == 1) begin
        chk("single_grant", {30'd0, grant_id}, 32'd0);
        req_valid = 4'b0000;
      end
    end

    // 3: round robin from a fresh pointer, all valid with count 1
    rst_n = 1'b0;
    nclk();
    rst_n     = 1'b1;
    req_count = 16'h1111;
    req_valid = 4'hF;
    #1;
    last_done = 0;
    for (int k = 0; k < 5; k++) begin
      exp_id = k % 4;
      chk($sformatf("rr_ready_%0d", k), {28'd0, req_ready}, 32'd1 << exp_id);
      nclk();
      chk($sformatf("rr_grant_%0d", k), {30'd0, grant_id}, exp_id);
      chk($sformatf("rr_busy_%0d", k), {31'd0, busy}, 32'd1);
      chk($sformatf("rr_led_%0d", k), {31'd0, led}, 32'd1);
      bad = 0;
      got = 1'b0;
      for (int c = 0; (c < 200) && !got; c++) begin
        if (done) begin
          got = 1'b1;
        end else begin
          if (req_ready != 4'b0000) bad++;
          nclk();
        end
      end
      chk($sformatf("rr_done_seen_%0d", k), {31'd0, got}, 32'd1);
      chk($sformatf("rr_no_grant_busy_%0d", k), bad, 32'd0);
      if (k > 0) chk($sformatf("rr_interval_%0d", k), cyc - last_done, 32'd121);
      last_done = cyc;
    end
    req_valid = 4'h0;

    // 4: zero-count code from requester 2
    nclk();
    req_count[11:8] = 4'd0;
    req_valid       = 4'b0100;
    #1;
    chk("zero_ready", {28'd0, req_ready}, 32'h4);
    nclk();
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    chk("zero_led", {31'd0, led}, 32'd0);
    chk("zero_grant", {30'd0, grant_id}, 32'd2);
    chk("zero_reaccept", {28'd0, req_ready}, 32'h4);
    req_valid = 4'b0000;
    nclk();
    chk("zero_done_once", {31'd0, done}, 32'd0);
    chk("zero_led_after", {31'd0, led}, 32'd0);

    // 5: reset in the middle of an ON phase
    req_count[3:0] = 4'd2;
    req_valid      = 4'b0001;
    #1;
    chk("midrst_ready", {28'd0, req_ready}, 32'd1);
    for (int n = 1; n <= 10; n++) begin
      nclk();
      if (n == 1) req_valid = 4'b0000;
    end
    chk("midrst_led_on", {31'd0, led}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_led_off", {31'd0, led}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    req_valid      = 4'b0011;
    req_count[7:4] = 4'd1;
    nclk(); nclk();
    chk("midrst_no_done", {31'd0, done}, 32'd0);
    chk("midrst_ready_held", {28'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_ptr0", {28'd0, req_ready}, 32'd1);
    req_valid = 4'b0000;
    nclk();

    // 6: count is sampled at accept; later changes ignored
    req_count = 16'h2222;
    req_valid = 4'b0001;
    #1;
    chk("sample_ready", {28'd0, req_ready}, 32'd1);
    for (int n = 1; n <= 171; n++) begin
      nclk();
      exp_led = ((n >= 1) && (n <= 20)) || ((n >= 51) && (n <= 70));
      chk($sformatf("sample_led_%0d", n), {31'd0, led}, {31'd0, exp_led});
      chk($sformatf("sample_done_%0d", n), {31'd0, done}, {31'd0, (n == 171)});
      chk($sformatf("sample_ready_%0d", n), {28'd0, req_ready}, (n == 171) ? 32'h2 : 32'h0);
      if (n == 1) req_valid = 4'hF;
      if (n == 5) req_count[3:0] = 4'd7;
    end
    chk("sample_busy_end", {31'd0, busy}, 32'd0);
    req_valid = 4'h0;
    nclk();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
